// File: rtl/ahb_burst_tracker_if.sv
// AHB-Lite address-phase pins plus the data-phase beat report produced by the tracker.
// The master side drives the bus pins; the slave side is the tracker itself.
interface ahb_burst_tracker_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16
);
    localparam int OFF_W = $clog2(LINE_BYTES);

    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hwrite;
    logic              hready;

    logic [ADDR_W-1:0] read_addr;
    logic [OFF_W-1:0]  read_offset;
    logic [1:0]        trans_out;
    logic              data_valid;
    logic [4:0]        beat_idx;
    logic              burst_done;
    logic              early_term;
    logic              err;

    // An address phase is taken only when hready is high and htrans is NONSEQ/SEQ;
    // every data-phase output describes the phase taken on the previous clock.
    modport master (
        output haddr, htrans, hburst, hsize, hwrite, hready,
        input  read_addr, read_offset, trans_out, data_valid, beat_idx,
               burst_done, early_term, err
    );

    modport slave (
        input  haddr, htrans, hburst, hsize, hwrite, hready,
        output read_addr, read_offset, trans_out, data_valid, beat_idx,
               burst_done, early_term, err
    );
endinterface

// File: rtl/ahb_burst_tracker.sv
// AHB-Lite burst tracker for the I-cache slave port: follows every burst type, generates
// the per-beat address and reports beat progress, completion and errors in the data phase.
module ahb_burst_tracker #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic               clk,
    input  logic               rst,
    ahb_burst_tracker_if.slave bus,
    output logic               dbg_state_o
);
    localparam int                BB       = DATA_W / 8;
    localparam int                OFF_W    = $clog2(LINE_BYTES);
    localparam int                ALIGN_W  = $clog2(BB);
    localparam logic [2:0]        SIZE_ENC = 3'(ALIGN_W);
    localparam logic [ADDR_W-1:0] BB_A     = ADDR_W'(BB);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [1:0]        TR_IDLE   = 2'd0;
    localparam logic [1:0]        TR_NONSEQ = 2'd2;
    localparam logic [1:0]        TR_SEQ    = 2'd3;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [4:0]        beat_q, beat_d;
    logic [4:0]        total_q, total_d;
    logic              wrap_q, wrap_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        trans_q, trans_d;
    logic              dv_q, dv_d;
    logic [4:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic              et_q, et_d;
    logic              err_q, err_d;

    logic              accept, is_nonseq, is_seq, bad;
    logic              nonseq_ok, seq_ok, seq_final, bounded_open, idle_req;
    logic [4:0]        new_total, beat_inc;
    logic              new_wrap;
    logic [ADDR_W-1:0] wmask, seq_addr;

    assign accept    = bus.hready & bus.htrans[1];
    assign is_nonseq = (bus.htrans == TR_NONSEQ);
    assign is_seq    = (bus.htrans == TR_SEQ);
    assign bad       = accept & (bus.hwrite | (bus.hsize != SIZE_ENC) |
                                 (is_seq & (state_q == S_IDLE)) |
                                 (is_nonseq & (|bus.haddr[ALIGN_W-1:0])));
    assign nonseq_ok = accept & is_nonseq & ~bad;
    assign seq_ok    = accept & is_seq & (state_q == S_ACTIVE) & ~bad;
    assign idle_req  = bus.hready & (bus.htrans == TR_IDLE);

    always_comb begin
        new_total = 5'd0;
        case (bus.hburst)
            3'd0:       new_total = 5'd1;
            3'd1:       new_total = 5'd0;
            3'd2, 3'd3: new_total = 5'd4;
            3'd4, 3'd5: new_total = 5'd8;
            default:    new_total = 5'd16;
        endcase
    end
    assign new_wrap = (bus.hburst == 3'd2) | (bus.hburst == 3'd4) | (bus.hburst == 3'd6);

    // Wrap boundary is total*BB bytes; only the bits inside it advance, the rest stay put.
    assign wmask     = (ADDR_W'(total_q) << ALIGN_W) - ONE_A;
    assign seq_addr  = wrap_q ? ((cur_addr_q & ~wmask) | ((cur_addr_q + BB_A) & wmask))
                              : (cur_addr_q + BB_A);
    assign beat_inc  = (beat_q == 5'd31) ? 5'd31 : (beat_q + 5'd1);
    assign seq_final = (total_q != 5'd0) && (beat_inc == total_q);
    assign bounded_open = (state_q == S_ACTIVE) && (total_q != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            beat_q     <= '0;
            total_q    <= '0;
            wrap_q     <= 1'b0;
            rd_addr_q  <= '0;
            trans_q    <= TR_IDLE;
            dv_q       <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            et_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            beat_q     <= beat_d;
            total_q    <= total_d;
            wrap_q     <= wrap_d;
            rd_addr_q  <= rd_addr_d;
            trans_q    <= trans_d;
            dv_q       <= dv_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            et_q       <= et_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        beat_d     = beat_q;
        total_d    = total_q;
        wrap_d     = wrap_q;
        if (nonseq_ok) begin
            cur_addr_d = bus.haddr;
            beat_d     = 5'd1;
            total_d    = new_total;
            wrap_d     = new_wrap;
            state_d    = (new_total == 5'd1) ? S_IDLE : S_ACTIVE;
        end else if (seq_ok) begin
            cur_addr_d = seq_addr;
            beat_d     = beat_inc;
            state_d    = seq_final ? S_IDLE : S_ACTIVE;
        end else if (accept & is_nonseq) begin
            state_d = S_IDLE;
        end else if (idle_req) begin
            state_d = S_IDLE;
        end
    end

    // Non-accepting cycles keep address and beat index; only the pulses and valid drop.
    always_comb begin
        rd_addr_d = rd_addr_q;
        idx_d     = idx_q;
        trans_d   = TR_IDLE;
        dv_d      = 1'b0;
        done_d    = 1'b0;
        et_d      = 1'b0;
        err_d     = bad;
        if (nonseq_ok) begin
            rd_addr_d = bus.haddr;
            idx_d     = 5'd1;
            trans_d   = TR_NONSEQ;
            dv_d      = 1'b1;
            done_d    = (new_total == 5'd1);
            et_d      = bounded_open;
        end else if (seq_ok) begin
            rd_addr_d = seq_addr;
            idx_d     = beat_inc;
            trans_d   = TR_SEQ;
            dv_d      = 1'b1;
            done_d    = seq_final;
        end else if (idle_req) begin
            et_d = bounded_open;
        end
    end

    assign bus.read_addr   = rd_addr_q;
    assign bus.read_offset = rd_addr_q[OFF_W-1:0];
    assign bus.trans_out   = trans_q;
    assign bus.data_valid  = dv_q;
    assign bus.beat_idx    = idx_q;
    assign bus.burst_done  = done_q;
    assign bus.early_term  = et_q;
    assign bus.err         = err_q;
    assign dbg_state_o     = (state_q == S_ACTIVE);
endmodule

// File: tb/tb_ahb_burst_tracker.sv
// Bench for ahb_burst_tracker: directed and random bursts scored against a burst-level model,
// plus a directed WRAP8 run on a 64-bit instance.
module tb_ahb_burst_tracker;
    localparam int         BB = 4;
    localparam logic [2:0] SZ = 3'd2;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

    typedef struct packed {
        int          cyc;
        logic        dv;
        logic        er;
        logic        et;
        logic [31:0] addr;
        logic [1:0]  tr;
        logic [4:0]  idx;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_burst_tracker_if #(.ADDR_W(32), .LINE_BYTES(16)) bus ();
    ahb_burst_tracker_if #(.ADDR_W(32), .LINE_BYTES(64)) bus64 ();
    logic dbg_state, dbg_state64;

    ahb_burst_tracker #(.ADDR_W(32), .DATA_W(32), .LINE_BYTES(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
    );
    ahb_burst_tracker #(.ADDR_W(32), .DATA_W(64), .LINE_BYTES(64)) u_dut64 (
        .clk(clk), .rst(rst), .bus(bus64), .dbg_state_o(dbg_state64)
    );

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (burst level) ----------------
    bit          m_active = 0;
    int          m_len = 0;
    bit          m_wrap = 0;
    int          m_k = 0;
    logic [31:0] m_start = '0;
    logic [31:0] m_last_addr = '0;
    logic [4:0]  m_last_idx = '0;

    function automatic int len_of(input logic [2:0] bu);
        case (bu)
            3'd0: return 1;
            3'd1: return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default: return 16;
        endcase
    endfunction

    // Address of beat k (1-based) from the burst start: wrapping bursts rotate inside an
    // aligned block of len*bb bytes, incrementing ones just step by bb modulo 2^32.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input bit wrap, input int k, input int bb);
        longint s, w, base, off;
        s = longint'(start);
        if (wrap) begin
            w    = longint'(len * bb);
            base = s - (s % w);
            off  = (s - base + longint'((k - 1) * bb)) % w;
            return 32'(base + off);
        end
        return 32'(s + longint'((k - 1) * bb));
    endfunction

    task automatic push(input logic dv, input logic er, input logic et, input logic [31:0] a,
                        input logic [1:0] tr, input logic [4:0] idx, input logic done);
        exp_t it;
        it.cyc = cyc + 1; it.dv = dv; it.er = er; it.et = et;
        it.addr = a; it.tr = tr; it.idx = idx; it.done = done;
        exp_q.push_back(it);
    endtask

    task automatic model_step(input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] ad,
                              input logic rdy, input logic wr, input logic [2:0] sz);
        bit          acc, bad, et, done;
        logic [31:0] a;
        acc = rdy && tr[1];
        if (acc) begin
            bad = wr || (sz != SZ) || (tr == T_SEQ && !m_active) || (tr == T_NONSEQ && (ad % BB) != 0);
            if (bad) begin
                push(1'b0, 1'b1, 1'b0, m_last_addr, T_IDLE, m_last_idx, 1'b0);
                if (tr == T_NONSEQ) m_active = 0;
            end else if (tr == T_NONSEQ) begin
                et = m_active && (m_len != 0);
                m_start = ad; m_len = len_of(bu); m_k = 1;
                m_wrap = (bu == 3'd2 || bu == 3'd4 || bu == 3'd6);
                done = (m_len == 1);
                m_active = !done;
                m_last_addr = ad; m_last_idx = 5'd1;
                push(1'b1, 1'b0, et, ad, T_NONSEQ, 5'd1, done);
            end else begin
                m_k++;
                a = beat_addr(m_start, m_len, m_wrap, m_k, BB);
                done = (m_len != 0) && (m_k == m_len);
                m_last_addr = a; m_last_idx = (m_k > 31) ? 5'd31 : 5'(m_k);
                push(1'b1, 1'b0, 1'b0, a, T_SEQ, m_last_idx, done);
                if (done) m_active = 0;
            end
        end else if (rdy && tr == T_IDLE && m_active) begin
            if (m_len != 0) push(1'b0, 1'b0, 1'b1, m_last_addr, T_IDLE, m_last_idx, 1'b0);
            m_active = 0;
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_len = 0; m_k = 0; m_wrap = 0;
        m_start = '0; m_last_addr = '0; m_last_idx = '0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] ad,
                         input logic rdy, input logic wr, input logic [2:0] sz);
        bus.htrans = tr; bus.hburst = bu; bus.haddr = ad;
        bus.hready = rdy; bus.hwrite = wr; bus.hsize = sz;
        model_step(tr, bu, ad, rdy, wr, sz);
        @(posedge clk); #1;
    endtask

    task automatic run_burst(input logic [2:0] bu, input logic [31:0] start, input int n_issue);
        if ($urandom_range(0, 9) < 2) drive(T_NONSEQ, bu, start, 1'b0, 1'b0, SZ);
        drive(T_NONSEQ, bu, start, 1'b1, 1'b0, SZ);
        for (int b = 2; b <= n_issue; b++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) repeat ($urandom_range(1, 2)) drive(T_SEQ, bu, $urandom, 1'b0, 1'b0, SZ);
            else if (r < 3) drive(T_BUSY, bu, $urandom, 1'b1, 1'b0, SZ);
            drive(T_SEQ, bu, $urandom, 1'b1, 1'b0, SZ);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 4) == 0) a[31:8] = '1;
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic check_reset();
        n_checks++;
        if (!bus.data_valid && !bus.err && !bus.early_term && !bus.burst_done) n_pass++;
        else $display("FAIL reset_pulses: got dv=%0d err=%0d et=%0d done=%0d, required all 0",
                      bus.data_valid, bus.err, bus.early_term, bus.burst_done);
        n_checks++;
        if (bus.read_addr == 0 && bus.read_offset == 0 && bus.beat_idx == 0 && bus.trans_out == 0) n_pass++;
        else $display("FAIL reset_data: got addr=%h off=%h idx=%0d tr=%0d, required all 0",
                      bus.read_addr, bus.read_offset, bus.beat_idx, bus.trans_out);
        n_checks++;
        if (dbg_state == 1'b0) n_pass++;
        else $display("FAIL reset_state: got %0d, required 0", dbg_state);
    endtask

    task automatic reset_mid();
        drive(T_BUSY, 3'd2, 32'h0, 1'b1, 1'b0, SZ);
        rst = 1'b1;
        bus.htrans = T_IDLE; bus.hready = 1'b1;
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] lv_addr = '0;
    logic [4:0]  lv_idx = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            lv_addr = '0; lv_idx = '0;
        end else if (bus.data_valid || bus.err || bus.early_term) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: got dv=%0d err=%0d et=%0d addr=%h at cycle %0d, required no output",
                         bus.data_valid, bus.err, bus.early_term, bus.read_addr, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.data_valid == mon_e.dv && bus.err == mon_e.er && bus.early_term == mon_e.et &&
                    bus.read_addr == mon_e.addr && bus.read_offset == mon_e.addr[3:0] &&
                    bus.trans_out == mon_e.tr && bus.beat_idx == mon_e.idx &&
                    bus.burst_done == mon_e.done && cyc == mon_e.cyc)
                    n_pass++;
                else
                    $display("FAIL beat_check: got dv=%0d err=%0d et=%0d addr=%h off=%h tr=%0d idx=%0d done=%0d cyc=%0d, required dv=%0d err=%0d et=%0d addr=%h off=%h tr=%0d idx=%0d done=%0d cyc=%0d",
                             bus.data_valid, bus.err, bus.early_term, bus.read_addr, bus.read_offset,
                             bus.trans_out, bus.beat_idx, bus.burst_done, cyc,
                             mon_e.dv, mon_e.er, mon_e.et, mon_e.addr, mon_e.addr[3:0],
                             mon_e.tr, mon_e.idx, mon_e.done, mon_e.cyc);
                lv_addr = mon_e.addr; lv_idx = mon_e.idx;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                $display("FAIL missing_output: got nothing at cycle %0d, required addr=%h dv=%0d err=%0d et=%0d",
                         cyc, mon_e.addr, mon_e.dv, mon_e.er, mon_e.et);
                lv_addr = mon_e.addr; lv_idx = mon_e.idx;
            end
            n_checks++;
            if (bus.trans_out == T_IDLE && !bus.burst_done && bus.read_addr == lv_addr && bus.beat_idx == lv_idx)
                n_pass++;
            else
                $display("FAIL idle_hold: got tr=%0d done=%0d addr=%h idx=%0d, required tr=0 done=0 addr=%h idx=%0d",
                         bus.trans_out, bus.burst_done, bus.read_addr, bus.beat_idx, lv_addr, lv_idx);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.htrans = T_IDLE; bus.hburst = 3'd0; bus.haddr = '0;
        bus.hready = 1'b1; bus.hwrite = 1'b0; bus.hsize = SZ;
        bus64.htrans = T_IDLE; bus64.hburst = 3'd0; bus64.haddr = '0;
        bus64.hready = 1'b1; bus64.hwrite = 1'b0; bus64.hsize = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        drive(T_NONSEQ, 3'd0, 32'h104, 1'b1, 1'b0, SZ);
        drive(T_NONSEQ, 3'd2, 32'h108, 1'b1, 1'b0, SZ);
        repeat (3) drive(T_SEQ, 3'd2, 32'h0, 1'b1, 1'b0, SZ);
        drive(T_NONSEQ, 3'd5, 32'h200, 1'b1, 1'b0, SZ);
        drive(T_SEQ, 3'd5, 32'h204, 1'b1, 1'b0, SZ);
        repeat (2) drive(T_SEQ, 3'd5, 32'h208, 1'b0, 1'b0, SZ);
        drive(T_SEQ, 3'd5, 32'h208, 1'b1, 1'b0, SZ);
        drive(T_BUSY, 3'd5, 32'h20C, 1'b1, 1'b0, SZ);
        repeat (5) drive(T_SEQ, 3'd5, 32'h0, 1'b1, 1'b0, SZ);
        drive(T_NONSEQ, 3'd7, 32'h300, 1'b1, 1'b0, SZ);
        repeat (4) drive(T_SEQ, 3'd7, 32'h0, 1'b1, 1'b0, SZ);
        drive(T_NONSEQ, 3'd0, 32'h400, 1'b1, 1'b0, SZ);
        drive(T_NONSEQ, 3'd0, 32'h500, 1'b1, 1'b1, SZ);
        drive(T_SEQ, 3'd1, 32'h504, 1'b1, 1'b0, SZ);
        drive(T_NONSEQ, 3'd3, 32'h700, 1'b1, 1'b0, SZ);
        drive(T_SEQ, 3'd3, 32'h0, 1'b1, 1'b0, SZ);
        drive(T_IDLE, 3'd0, 32'h0, 1'b1, 1'b0, SZ);
        drive(T_NONSEQ, 3'd2, 32'h508, 1'b1, 1'b0, SZ);
        drive(T_SEQ, 3'd2, 32'h0, 1'b1, 1'b0, SZ);
        reset_mid();
        drive(T_NONSEQ, 3'd3, 32'h600, 1'b1, 1'b0, SZ);
        repeat (3) drive(T_SEQ, 3'd3, 32'h0, 1'b1, 1'b0, SZ);

        for (int n = 0; n < 60; n++) begin
            int          r, len, n_issue;
            logic [2:0]  bu;
            r = $urandom_range(0, 99);
            if (r < 5) drive(T_NONSEQ, 3'd0, rand_addr(), 1'b1, 1'b1, SZ);
            else if (r < 9) drive(T_NONSEQ, 3'($urandom_range(0, 7)), rand_addr() | 32'h1, 1'b1, 1'b0, SZ);
            else if (r < 12) drive(T_NONSEQ, 3'd0, rand_addr(), 1'b1, 1'b0, 3'd3);
            else if (r < 15) drive(T_SEQ, 3'd1, $urandom, 1'b1, 1'b0, SZ);
            else begin
                bu = 3'($urandom_range(0, 7));
                len = len_of(bu);
                if (len == 0) n_issue = $urandom_range(1, 40);
                else n_issue = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : len;
                run_burst(bu, rand_addr(), n_issue);
            end
            if ($urandom_range(0, 3) == 0) drive(T_IDLE, 3'd0, 32'h0, 1'b1, 1'b0, SZ);
        end
        repeat (4) drive(T_IDLE, 3'd0, 32'h0, 1'b1, 1'b0, SZ);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d outstanding beats, required 0", exp_q.size());

        bus64.haddr = 32'h1038; bus64.hburst = 3'd4; bus64.htrans = T_NONSEQ;
        for (int k = 1; k <= 8; k++) begin
            logic [31:0] e;
            @(posedge clk); #1;
            bus64.htrans = (k < 8) ? T_SEQ : T_IDLE;
            e = beat_addr(32'h1038, 8, 1'b1, k, 8);
            n_checks++;
            if (bus64.data_valid && bus64.read_addr == e && bus64.read_offset == e[5:0] &&
                bus64.beat_idx == 5'(k) && bus64.burst_done == (k == 8))
                n_pass++;
            else
                $display("FAIL wrap8_w64: beat %0d got dv=%0d addr=%h off=%h idx=%0d done=%0d, required dv=1 addr=%h off=%h idx=%0d done=%0d",
                         k, bus64.data_valid, bus64.read_addr, bus64.read_offset, bus64.beat_idx,
                         bus64.burst_done, e, e[5:0], k, (k == 8));
        end
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
